// File: rtl/ias_pkg.sv
// Shared definitions for the IAS instruction fetch unit: default field widths
// and the fetch state encoding.
package ias_pkg;

   localparam int IAS_OP_W   = 8;
   localparam int IAS_ADDR_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_ISSUE_L = 2'd2,
      ST_ISSUE_R = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/ias_instr_reg.sv
// Instruction holding register (used for both IR and IBR): a plain W-bit
// register with a load enable and asynchronous active-low clear.
module ias_instr_reg #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   // Hold the current value unless a load is requested.
   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = d;
      end
   end

   // Storage flop, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

// File: rtl/ias_fetch_unit.sv
// IAS-style instruction fetch unit. Each memory word holds two instructions
// (left = upper half, right = lower half). The unit fetches a word into IR/IBR,
// issues the left then the right instruction over a valid/ready handshake,
// and handles branch redirects (optionally to the right half) and halts.
// Optional build macro IAS_FETCH_COUNT_EN adds a 16-bit issued-instruction
// counter output (instr_count).
module ias_fetch_unit
   import ias_pkg::*;
#(
   parameter int OP_W   = IAS_OP_W,
   parameter int ADDR_W = IAS_ADDR_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          halt,
   output logic                          mem_req,
   output logic [ADDR_W-1:0]             mem_addr,
   input  logic                          mem_ack,
   input  logic [2*(OP_W+ADDR_W)-1:0]    mem_rdata,
   output logic                          ir_valid,
   input  logic                          ir_ready,
   output logic [OP_W-1:0]               ir_opcode,
   output logic [ADDR_W-1:0]             ir_addr,
   input  logic                          jump,
   input  logic [ADDR_W-1:0]             jump_addr,
   input  logic                          jump_right,
   output logic [ADDR_W-1:0]             pc
`ifdef IAS_FETCH_COUNT_EN
   ,
   output logic [15:0]                   instr_count
`endif
);

   localparam int INSTR_W = OP_W + ADDR_W;

   fetch_state_e        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                right_q, right_d;      // next fetch starts at the right half
   logic                jpend_q, jpend_d;      // jump seen mid-request: drop the returning data
   logic                bubble_q, bubble_d;    // one idle cycle between left and right issue
   logic                ir_load, ibr_load;
   logic [INSTR_W-1:0]  ir_d, ir_q, ibr_q;
   logic [INSTR_W-1:0]  word_upper, word_lower;
   logic                transfer;

   assign word_upper = mem_rdata[2*INSTR_W-1:INSTR_W];
   assign word_lower = mem_rdata[INSTR_W-1:0];

   assign mem_req   = (state_q == ST_REQ);
   assign mem_addr  = mem_addr_q;
   assign ir_valid  = ((state_q == ST_ISSUE_L) || (state_q == ST_ISSUE_R)) && !bubble_q;
   assign ir_opcode = ir_q[INSTR_W-1:ADDR_W];
   assign ir_addr   = ir_q[ADDR_W-1:0];
   assign pc        = pc_q;
   assign transfer  = ir_valid && ir_ready;

   // Next-state logic: fetch sequencing, jump redirect and halt handling.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_addr_d = mem_addr_q;
      right_d    = right_q;
      jpend_d    = jpend_q;
      bubble_d   = 1'b0;
      ir_load    = 1'b0;
      ibr_load   = 1'b0;
      ir_d       = ibr_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_REQ;
               mem_addr_d = pc_q;
            end
         end
         ST_REQ: begin
            if (mem_ack) begin
               if (jump || jpend_q) begin
                  // Redirected while in flight: the returned word is stale.
                  jpend_d = 1'b0;
                  if (jump) begin
                     pc_d       = jump_addr;
                     right_d    = jump_right;
                     mem_addr_d = jump_addr;
                  end else begin
                     mem_addr_d = pc_q;
                  end
                  state_d = halt ? ST_IDLE : ST_REQ;
               end else begin
                  pc_d    = pc_q + ADDR_W'(1);
                  right_d = 1'b0;
                  if (halt) begin
                     state_d = ST_IDLE;
                  end else begin
                     ir_load  = 1'b1;
                     ibr_load = 1'b1;
                     ir_d     = right_q ? word_lower : word_upper;
                     state_d  = right_q ? ST_ISSUE_R : ST_ISSUE_L;
                  end
               end
            end else if (jump) begin
               // Keep the request up; retarget once the current one completes.
               pc_d    = jump_addr;
               right_d = jump_right;
               jpend_d = 1'b1;
            end
         end
         ST_ISSUE_L, ST_ISSUE_R: begin
            if (halt) begin
               state_d = ST_IDLE;
               if (jump) begin
                  pc_d    = jump_addr;
                  right_d = jump_right;
               end
            end else if (jump) begin
               pc_d       = jump_addr;
               right_d    = jump_right;
               mem_addr_d = jump_addr;
               state_d    = ST_REQ;
            end else if (transfer) begin
               if (state_q == ST_ISSUE_L) begin
                  ir_load  = 1'b1;
                  bubble_d = 1'b1;
                  state_d  = ST_ISSUE_R;
               end else begin
                  mem_addr_d = pc_q;
                  state_d    = ST_REQ;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and address registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         mem_addr_q <= '0;
         right_q    <= 1'b0;
         jpend_q    <= 1'b0;
         bubble_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_addr_q <= mem_addr_d;
         right_q    <= right_d;
         jpend_q    <= jpend_d;
         bubble_q   <= bubble_d;
      end
   end

   ias_instr_reg #(.W(INSTR_W)) u_ir (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ir_load),
      .d     (ir_d),
      .q     (ir_q)
   );

   ias_instr_reg #(.W(INSTR_W)) u_ibr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ibr_load),
      .d     (word_lower),
      .q     (ibr_q)
   );

`ifdef IAS_FETCH_COUNT_EN
   logic [15:0] cnt_q, cnt_d;

   // Count every completed issue handshake, wrapping at 16 bits.
   always_comb begin
      cnt_d = cnt_q + 16'(transfer);
   end

   // Issue counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign instr_count = cnt_q;
`endif

endmodule
